// File: rtl/i2s_adc_receiver.sv
// I2S slave receiver for the ADC capture path.
// Oversamples externally driven BCLK/LRCLK/DATA with the system clock,
// deserializes one left and one right word per frame and hands the stereo
// pair downstream through a valid/ready handshake.
module i2s_adc_receiver #(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              i2s_bclk,
    input  logic              i2s_lrclk,
    input  logic              i2s_data,
    output logic [DATA_W-1:0] sample_left,
    output logic [DATA_W-1:0] sample_right,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_LEFT      = 2'd2,
        ST_RIGHT     = 2'd3
    } state_t;

    // Synchronizer chains; all three inputs share the same depth so they stay aligned.
    logic [SYNC_STAGES-1:0] bclk_sync_r;
    logic [SYNC_STAGES-1:0] lrclk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   prev_bclk_r;
    logic                   lr_seen_r;

    // Edge-event stage: one registered snapshot per BCLK rise.
    logic                   ev_rise_r;
    logic                   ev_lr_chg_r;
    logic                   ev_lr_r;
    logic                   ev_data_r;

    logic                   sync_bclk_s;
    logic                   sync_lrclk_s;
    logic                   sync_data_s;
    logic                   bclk_rise_s;
    logic                   short_slot_s;

    state_t                 state_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [DATA_W-1:0]      shift_r;
    logic [DATA_W-1:0]      left_shadow_r;
    logic                   frame_bad_r;

    assign sync_bclk_s  = bclk_sync_r[SYNC_STAGES-1];
    assign sync_lrclk_s = lrclk_sync_r[SYNC_STAGES-1];
    assign sync_data_s  = data_sync_r[SYNC_STAGES-1];
    assign bclk_rise_s  = sync_bclk_s & ~prev_bclk_r;
    assign short_slot_s = (bit_cnt_r < CNT_FULL);

    // Synchronize the I2S pins and remember BCLK / LRCLK from the previous rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bclk_sync_r  <= '0;
            lrclk_sync_r <= '0;
            data_sync_r  <= '0;
            prev_bclk_r  <= 1'b0;
            lr_seen_r    <= 1'b0;
        end else begin
            bclk_sync_r  <= {bclk_sync_r[SYNC_STAGES-2:0], i2s_bclk};
            lrclk_sync_r <= {lrclk_sync_r[SYNC_STAGES-2:0], i2s_lrclk};
            data_sync_r  <= {data_sync_r[SYNC_STAGES-2:0], i2s_data};
            prev_bclk_r  <= sync_bclk_s;
            if (bclk_rise_s) begin
                lr_seen_r <= sync_lrclk_s;
            end else begin
                lr_seen_r <= lr_seen_r;
            end
        end
    end

    // Register each BCLK rise together with its LRCLK-change flag and data bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ev_rise_r   <= 1'b0;
            ev_lr_chg_r <= 1'b0;
            ev_lr_r     <= 1'b0;
            ev_data_r   <= 1'b0;
        end else begin
            ev_rise_r   <= bclk_rise_s;
            ev_lr_chg_r <= bclk_rise_s & (sync_lrclk_s != lr_seen_r);
            ev_lr_r     <= sync_lrclk_s;
            ev_data_r   <= sync_data_s;
        end
    end

    // Framing FSM, deserializer, output handshake and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= '0;
            shift_r       <= '0;
            left_shadow_r <= '0;
            frame_bad_r   <= 1'b0;
            sample_left   <= '0;
            sample_right  <= '0;
            sample_valid  <= 1'b0;
            overrun       <= 1'b0;
            frame_err     <= 1'b0;
        end else if (!enable) begin
            // Output words are deliberately kept so the consumer can still read them.
            state_r       <= ST_IDLE;
            bit_cnt_r     <= '0;
            shift_r       <= '0;
            left_shadow_r <= '0;
            frame_bad_r   <= 1'b0;
            sample_valid  <= 1'b0;
            overrun       <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // Consumed pair drops valid; a frame completing below overrides this.
            if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end else begin
                sample_valid <= sample_valid;
            end

            if (state_r == ST_IDLE) begin
                state_r <= ST_WAIT_SYNC;
            end else if (ev_rise_r) begin
                if (ev_lr_chg_r) begin
                    // Delay bit: its data is ignored and the new slot starts empty.
                    bit_cnt_r <= '0;
                    shift_r   <= '0;
                    case (state_r)
                        ST_WAIT_SYNC: begin
                            if (!ev_lr_r) begin
                                state_r     <= ST_LEFT;
                                frame_bad_r <= 1'b0;
                            end else begin
                                state_r <= ST_WAIT_SYNC;
                            end
                        end
                        ST_LEFT: begin
                            left_shadow_r <= shift_r;
                            state_r       <= ST_RIGHT;
                            if (short_slot_s) begin
                                frame_err   <= 1'b1;
                                frame_bad_r <= 1'b1;
                            end else begin
                                frame_bad_r <= frame_bad_r;
                            end
                        end
                        ST_RIGHT: begin
                            // This change also opens the next left slot.
                            state_r     <= ST_LEFT;
                            frame_bad_r <= 1'b0;
                            if (short_slot_s) begin
                                frame_err <= 1'b1;
                            end else if (frame_bad_r) begin
                                frame_err <= 1'b0;
                            end else if (!sample_valid || sample_ready) begin
                                sample_left  <= left_shadow_r;
                                sample_right <= shift_r;
                                sample_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                        default: begin
                            state_r <= ST_IDLE;
                        end
                    endcase
                end else if (short_slot_s) begin
                    shift_r   <= {shift_r[DATA_W-2:0], ev_data_r};
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                end else begin
                    shift_r   <= shift_r;
                    bit_cnt_r <= bit_cnt_r;
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed self-checking bench for i2s_adc_receiver (DATA_W=24, SYNC_STAGES=2,
// clk/BCLK = 8, 32-bit slots unless noted).
module tb_i2s_adc_receiver;

    localparam int DATA_W = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              i2s_bclk;
    logic              i2s_lrclk;
    logic              i2s_data;
    logic              sample_ready;
    logic [DATA_W-1:0] sample_left;
    logic [DATA_W-1:0] sample_right;
    logic              sample_valid;
    logic              overrun;
    logic              frame_err;

    int n_cmp = 0;
    int n_fail = 0;
    int valid_cycles = 0;
    int ferr_cycles = 0;
    int v0;
    int f0;
    logic [3:0] vhist;

    i2s_adc_receiver #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_data     (i2s_data),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // Count cycles in which valid / frame_err are high.
    always @(posedge clk) begin
        if (sample_valid === 1'b1) valid_cycles++;
        if (frame_err === 1'b1) ferr_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One BCLK period: 4 clk low, 4 clk high; valid is recorded on each high-phase negedge.
    task automatic send_bit(input logic b, input logic lr);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_data  = b;
        repeat (4) @(negedge clk);
        i2s_bclk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vhist[i] = sample_valid;
        end
    endtask

    // Slot bits after the delay bit: word MSB first, padding bits are 1.
    task automatic send_body(input logic [23:0] w, input logic lr, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < 24) send_bit(w[23 - i], lr);
            else        send_bit(1'b1, lr);
        end
    endtask

    task automatic send_slot(input logic [23:0] w, input logic lr, input int n);
        send_bit(1'b1, lr);
        send_body(w, lr, n - 1);
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int n);
        send_slot(l, 1'b0, n);
        send_slot(r, 1'b1, n);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; sample_ready = 1'b1;
        i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_data = 1'b0;
        @(negedge clk);

        // Reset while BCLK toggles
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("rst_left", 32'(sample_left), 32'h0);
        check("rst_right", 32'(sample_right), 32'h0);
        check("rst_valid", 32'(sample_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);

        // Basic frame, preceded by a partial right slot that must be discarded
        rst_n = 1'b1; enable = 1'b1;
        v0 = valid_cycles; f0 = ferr_cycles;
        send_slot(24'h0, 1'b1, 8);
        send_frame(24'hA5A5A5, 24'h3C3C3C, 32);
        check("basic_no_early_valid", 32'(valid_cycles - v0), 32'd0);
        send_bit(1'b1, 1'b0);
        check("basic_latency", 32'(vhist), 32'h8);
        check("basic_left", 32'(sample_left), 32'hA5A5A5);
        check("basic_right", 32'(sample_right), 32'h3C3C3C);
        send_body(24'h111111, 1'b0, 31);
        check("basic_valid_1cycle", 32'(valid_cycles - v0), 32'd1);
        check("basic_no_ferr", 32'(ferr_cycles - f0), 32'd0);

        // Backpressure: pair 111111/222222 held, 333333/444444 dropped
        sample_ready = 1'b0;
        send_slot(24'h222222, 1'b1, 32);
        send_frame(24'h333333, 24'h444444, 32);
        check("bp_valid_held", 32'(sample_valid), 32'h1);
        check("bp_no_overrun_yet", 32'(overrun), 32'h0);
        send_bit(1'b1, 1'b0);
        check("bp_valid_still", 32'(sample_valid), 32'h1);
        check("bp_overrun", 32'(overrun), 32'h1);
        check("bp_left", 32'(sample_left), 32'h111111);
        check("bp_right", 32'(sample_right), 32'h222222);
        sample_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_cleared", 32'(sample_valid), 32'h0);

        // Short slots: 5 short slots, no pair, then a good frame
        v0 = valid_cycles; f0 = ferr_cycles;
        send_body(24'h555555, 1'b0, 31);
        send_slot(24'h666666, 1'b1, 16);
        send_frame(24'h0, 24'h0, 16);
        send_frame(24'h0, 24'h0, 16);
        send_frame(24'h777777, 24'h888888, 32);
        check("short_no_valid", 32'(valid_cycles - v0), 32'd0);
        send_bit(1'b1, 1'b0);
        check("short_ferr_pulses", 32'(ferr_cycles - f0), 32'd5);
        check("short_recover_latency", 32'(vhist), 32'h8);
        check("short_recover_left", 32'(sample_left), 32'h777777);
        check("short_recover_right", 32'(sample_right), 32'h888888);

        // Mid-frame start: enable raised halfway through a right slot
        enable = 1'b0;
        send_body(24'h0, 1'b0, 31);
        send_bit(1'b1, 1'b1);
        send_body(24'hFFFFFF, 1'b1, 10);
        enable = 1'b1;
        v0 = valid_cycles;
        send_body(24'hFFFFFF, 1'b1, 21);
        send_frame(24'hABCDEF, 24'h123456, 32);
        check("mid_no_partial", 32'(valid_cycles - v0), 32'd0);
        send_bit(1'b1, 1'b0);
        check("mid_latency", 32'(vhist), 32'h8);
        check("mid_left", 32'(sample_left), 32'hABCDEF);
        check("mid_right", 32'(sample_right), 32'h123456);

        // Abort mid-left-slot with a pending pair and overrun set
        @(negedge clk);
        sample_ready = 1'b0;
        send_body(24'h135790, 1'b0, 31);
        send_slot(24'h2468AC, 1'b1, 32);
        send_frame(24'hFFFFFF, 24'hEEEEEE, 32);
        send_bit(1'b1, 1'b0);
        send_body(24'h0, 1'b0, 10);
        check("abort_pending_valid", 32'(sample_valid), 32'h1);
        check("abort_pending_overrun", 32'(overrun), 32'h1);
        enable = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(sample_valid), 32'h0);
        check("abort_overrun", 32'(overrun), 32'h0);
        check("abort_left_kept", 32'(sample_left), 32'h135790);
        check("abort_right_kept", 32'(sample_right), 32'h2468AC);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_rst_left", 32'(sample_left), 32'h0);
        check("abort_rst_right", 32'(sample_right), 32'h0);
        check("abort_rst_ferr", 32'(frame_err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_adc_receiver.md
# i2s_adc_receiver

I2S receiver for the ADC capture path. It is the receive-side counterpart of the DAC transmit path. It samples externally driven BCLK/LRCLK/DATA as a clock slave, oversampled by the system clock. It deserializes one left and one right word per frame and presents the stereo pair to downstream DSP logic through a valid/ready handshake.

## Interface
- DATA_W, 24: captured bits per channel, MSB-first; extra slot bits are ignored (legal 8..32).
- SYNC_STAGES, 2: synchronizer flops on each I2S input (legal ≥2).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  1 = receive; 0 = return to IDLE and clear status.
- i2s_bclk  in  1  external bit clock, asynchronous to clk.
- i2s_lrclk  in  1  external word select; 0 = left, 1 = right.
- i2s_data  in  1  external serial data.
- sample_left  out  DATA_W  left word of the last accepted frame.
- sample_right  out  DATA_W  right word of the last accepted frame.
- sample_valid  out  1  stereo pair available.
- sample_ready  in  1  consumer accepts the pair when high together with valid.
- overrun  out  1  sticky: a completed frame was dropped because valid was still pending.
- frame_err  out  1  one-cycle pulse: a slot ended with fewer than DATA_W data bits.

## Operation
- Synchronization:
  - All three I2S inputs pass through identical SYNC_STAGES chains, so they stay mutually aligned.
  - A further register holds the previous synchronized BCLK and LRCLK.
  - bclk_rise = sync_bclk & ~prev_bclk. All actions below occur only in cycles with bclk_rise.
- I2S framing:
  - An LRCLK change seen at a bclk_rise is the delay bit. The data bit at that edge is ignored.
  - Bit counter clears to 0 on the delay bit.
  - Each later bclk_rise shifts i2s_data into the channel shift register while count < DATA_W.
  - Counter saturates at DATA_W; further bits are ignored.
- States:
  - IDLE: entered on reset or enable=0. Moves to WAIT_SYNC when enable=1.
  - WAIT_SYNC: waits for an LRCLK 1→0 change, then goes to LEFT. Partial frames seen before this are discarded.
  - LEFT: on an LRCLK 0→1 change, latches the left shift value into the left shadow, then goes to RIGHT.
  - RIGHT: on an LRCLK 1→0 change, the frame is complete. State goes to LEFT (that change is also the delay bit of the next left slot).
- Short slot:
  - Condition: an LRCLK change while count < DATA_W.
  - frame_err pulses. The frame is marked bad and no pair is emitted for it.
  - Tracking continues; the next state follows the normal LEFT/RIGHT transitions.
- Frame completion (good frame):
  - sample_valid=0, or sample_valid=1 with sample_ready=1 in the same cycle: load sample_left (from the shadow) and sample_right (from the shift register), and set sample_valid=1.
  - sample_valid=1 with sample_ready=0: drop the new frame, keep the held pair, set overrun=1.
- Handshake:
  - sample_valid clears on valid&ready unless a new frame completes in that same cycle.
  - Output data is stable while valid is high.
- enable=0: next cycle state=IDLE, sample_valid=0, overrun=0, counters and shadows cleared. sample_left and sample_right keep their last values.

## Timing
- Reset values: sample_left=0, sample_right=0, sample_valid=0, overrun=0, frame_err=0, state=IDLE, all synchronizer and shift registers 0.
- Latency: the first clk edge that samples i2s_bclk high is edge 0. The action for that bclk_rise is registered at edge SYNC_STAGES+1.
  - This applies to shift, state change, sample_valid, overrun and frame_err alike.
- Input constraints:
  - BCLK high and low phases each ≥ 2 clk periods (clk ≥ 4×BCLK).
  - LRCLK and DATA change only on the BCLK falling edge.
- Pipeline: no bubble; frames can complete back-to-back every 2×slot BCLKs.
- Reset mid-frame: a synchronous clear on the next clk edge, with no output pulse; a partial frame is lost.
- Simultaneous events: frame completion with valid&ready in the same cycle loads the new pair and keeps valid=1 with no gap.

## Test plan
- Reset: hold rst_n=0 for 4 clk while BCLK toggles → all outputs 0; after release, no valid until a full frame is received.
- Basic frame: DATA_W=24, 32-bit slots, clk/BCLK=8, left=0xA5A5A5, right=0x3C3C3C, ready=1 → sample_valid high for exactly 1 cycle, SYNC_STAGES+1 clk after the BCLK rise that sees the LRCLK fall. sample_left=0xA5A5A5, sample_right=0x3C3C3C, frame_err=0.
- Backpressure: ready=0 across frames (0x111111/0x222222), then (0x333333/0x444444) → first pair held, valid stays 1, overrun=1 after the second frame; raising ready yields 0x111111/0x222222.
- Short slot: 16-bit slots with DATA_W=24 → frame_err pulses once per short slot; sample_valid never asserts; switching back to 32-bit slots yields valid frames.
- Mid-frame start: enable raised in the middle of a right slot → partial right discarded; first valid only after the following complete left+right and the next LRCLK fall.
- Abort: enable=0 (then rst_n=0) mid-left-slot with valid pending → next cycle valid=0 and overrun=0; sample data retained on enable drop and zeroed on reset.
